// File: rtl/tb_sim_monitor_pkg.sv
// tb_sim_monitor_pkg: shared types and constants for the simulation monitor.
// Dump channel modes, per-channel FSM states and a helper that decides
// whether a channel wants its dump window open this cycle.
package tb_sim_monitor_pkg;

   localparam int MODE_W = 2;
   localparam int EXIT_W = 32;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_TRIG    = 2'd2,
      MODE_ONESHOT = 2'd3
   } dump_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INIT = 3'd1,
      ST_WAIT = 3'd2,
      ST_OFF  = 3'd3,
      ST_DONE = 3'd4
   } dump_state_e;

   // A channel wants a window when forced on, or when triggered and its trigger is high.
   function automatic logic mode_armed(dump_mode_e m, logic trig);
      return (m == MODE_ON) ||
             (((m == MODE_TRIG) || (m == MODE_ONESHOT)) && trig);
   endfunction

endpackage

// File: rtl/tb_sim_monitor_dump_ch.sv
// tb_dump_ch_fsm: one dump-window channel.
// IDLE -> INIT (1 cycle, start pulse) -> WAIT -> OFF (1 cycle, stop pulse)
// -> IDLE, or -> DONE in one-shot mode. halt_i forces open windows closed
// through OFF and then parks the channel in IDLE.
module tb_dump_ch_fsm
   import tb_sim_monitor_pkg::*;
#(
   parameter int SEQ_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  dump_mode_e       mode_i,
   input  logic             trig_i,
   input  logic             halt_i,
   output logic             dump_on_o,
   output logic             dump_start_o,
   output logic             dump_stop_o,
   output logic [SEQ_W-1:0] seq_o,
   output dump_state_e      state_o
);

   dump_state_e      r_state;
   dump_state_e      w_next;
   logic [SEQ_W-1:0] r_seq;
   logic             w_armed;

   assign w_armed = mode_armed(mode_i, trig_i);

   // State register; reset drops any open window without a stop pulse.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; halt overrides mode so windows close and none reopen.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (!halt_i && w_armed) w_next = ST_INIT;
         ST_INIT: w_next = halt_i ? ST_OFF : ST_WAIT;
         ST_WAIT: if (halt_i || !w_armed) w_next = ST_OFF;
         ST_OFF:  w_next = (!halt_i && (mode_i == MODE_ONESHOT)) ? ST_DONE : ST_IDLE;
         ST_DONE: if (halt_i || (mode_i != MODE_ONESHOT)) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Window index: advances as the window leaves INIT, wrapping naturally.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_seq <= '0;
      end else if (r_state == ST_INIT) begin
         r_seq <= r_seq + SEQ_W'(1);
      end
   end

   assign dump_on_o    = (r_state == ST_INIT) || (r_state == ST_WAIT);
   assign dump_start_o = (r_state == ST_INIT);
   assign dump_stop_o  = (r_state == ST_OFF);
   assign seq_o        = r_seq;
   assign state_o      = r_state;

endmodule

// File: rtl/tb_sim_monitor.sv
// tb_sim_monitor: simulation monitor with NUM_CH dump-window channels, a
// saturating cycle counter, watchdog, heartbeat and sticky exit status.
// Optional event trace: define TB_SIM_MONITOR_TRACE_EN.
// exit_valid_i is a strobe with no back-pressure: the first strobe seen while
// not halted is taken on that edge, every later strobe is ignored.
module tb_sim_monitor
   import tb_sim_monitor_pkg::*;
#(
   parameter int NUM_CH           = 4,
   parameter int CNT_W            = 32,
   parameter int HEARTBEAT_CYCLES = 100000,
   parameter int SEQ_W            = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_CH*MODE_W-1:0] mode_i,
   input  logic [NUM_CH-1:0]       trig_i,
   input  logic [CNT_W-1:0]        max_cycles_i,
   input  logic                    exit_valid_i,
   input  logic [EXIT_W-1:0]       exit_value_i,
   output logic [NUM_CH-1:0]       dump_on_o,
   output logic [NUM_CH-1:0]       dump_start_o,
   output logic [NUM_CH-1:0]       dump_stop_o,
   output logic [NUM_CH*SEQ_W-1:0] dump_seq_o,
   output logic [CNT_W-1:0]        cycle_cnt_o,
   output logic                    heartbeat_o,
   output logic                    timeout_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic [EXIT_W-1:0]       exit_code_o,
   output logic [NUM_CH*3-1:0]     dbg_state_o
);

   localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

   logic [CNT_W-1:0]  r_cycle_cnt;
   logic [HB_W-1:0]   r_hb_cnt;
   logic              r_timeout;
   logic              r_done;
   logic              r_pass;
   logic [EXIT_W-1:0] r_exit_code;
   logic              w_halt;
   logic              w_exit_take;
   logic              w_wd_hit;

   assign w_halt      = r_done || r_timeout;
   assign w_exit_take = exit_valid_i && !w_halt;
   assign w_wd_hit    = (max_cycles_i != '0) && (r_cycle_cnt >= max_cycles_i) &&
                        !w_halt && !w_exit_take;

   // Cycle counter: counts from reset release, freezes on halt, saturates.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cycle_cnt <= '0;
      end else if (!w_halt && (r_cycle_cnt != '1)) begin
         r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
   end

   // Heartbeat phase counter, wraps every HEARTBEAT_CYCLES and stops on halt.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_hb_cnt <= '0;
      end else if (!w_halt) begin
         r_hb_cnt <= (r_hb_cnt == HB_LAST) ? '0 : r_hb_cnt + HB_W'(1);
      end
   end

   // Sticky status: exit beats a simultaneous watchdog expiry.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_timeout   <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_exit_code <= '0;
      end else if (w_exit_take) begin
         r_done      <= 1'b1;
         r_pass      <= (exit_value_i == '0);
         r_exit_code <= exit_value_i;
      end else if (w_wd_hit) begin
         r_timeout   <= 1'b1;
      end
   end

   assign cycle_cnt_o = r_cycle_cnt;
   assign heartbeat_o = (r_hb_cnt == HB_LAST) && !w_halt;
   assign timeout_o   = r_timeout;
   assign done_o      = r_done;
   assign pass_o      = r_pass;
   assign exit_code_o = r_exit_code;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dump_mode_e  w_mode;
      dump_state_e w_state;

      assign w_mode = dump_mode_e'(mode_i[g*MODE_W +: MODE_W]);

      tb_dump_ch_fsm #(
         .SEQ_W (SEQ_W)
      ) u_ch (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .mode_i       (w_mode),
         .trig_i       (trig_i[g]),
         .halt_i       (w_halt),
         .dump_on_o    (dump_on_o[g]),
         .dump_start_o (dump_start_o[g]),
         .dump_stop_o  (dump_stop_o[g]),
         .seq_o        (dump_seq_o[g*SEQ_W +: SEQ_W]),
         .state_o      (w_state)
      );

      assign dbg_state_o[g*3 +: 3] = w_state;
   end

`ifdef TB_SIM_MONITOR_TRACE_EN
   // Event log: one line per start/stop/heartbeat/timeout/exit seen this cycle.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (dump_start_o[c])
               $display("%0t tb_sim_monitor start ch=%0d seq=%0d code=%0h",
                        $time, c, dump_seq_o[c*SEQ_W +: SEQ_W], exit_code_o);
            if (dump_stop_o[c])
               $display("%0t tb_sim_monitor stop ch=%0d seq=%0d code=%0h",
                        $time, c, dump_seq_o[c*SEQ_W +: SEQ_W], exit_code_o);
         end
         if (heartbeat_o)
            $display("%0t tb_sim_monitor heartbeat cycle=%0d", $time, cycle_cnt_o);
         if (w_wd_hit)
            $display("%0t tb_sim_monitor timeout cycle=%0d", $time, cycle_cnt_o);
         if (w_exit_take)
            $display("%0t tb_sim_monitor exit code=%0h", $time, exit_value_i);
      end
   end
`endif

endmodule

// File: tb/tb_tb_sim_monitor.sv
// Bench for tb_sim_monitor: table of per-cycle vectors for the channel
// windows, plus hand sequences for timeout, exit, reset and seq wrap.
module tb_tb_sim_monitor;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int HB     = 16;
   localparam int SEQ_W  = 8;

   logic                     clk_i;
   logic                     rst_ni;
   logic [NUM_CH*2-1:0]      mode_i;
   logic [NUM_CH-1:0]        trig_i;
   logic [CNT_W-1:0]         max_cycles_i;
   logic                     exit_valid_i;
   logic [31:0]              exit_value_i;
   logic [NUM_CH-1:0]        dump_on_o;
   logic [NUM_CH-1:0]        dump_start_o;
   logic [NUM_CH-1:0]        dump_stop_o;
   logic [NUM_CH*SEQ_W-1:0]  dump_seq_o;
   logic [CNT_W-1:0]         cycle_cnt_o;
   logic                     heartbeat_o;
   logic                     timeout_o;
   logic                     done_o;
   logic                     pass_o;
   logic [31:0]              exit_code_o;
   logic [NUM_CH*3-1:0]      dbg_state_o;

   tb_sim_monitor #(
      .NUM_CH           (NUM_CH),
      .CNT_W            (CNT_W),
      .HEARTBEAT_CYCLES (HB),
      .SEQ_W            (SEQ_W)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .mode_i       (mode_i),
      .trig_i       (trig_i),
      .max_cycles_i (max_cycles_i),
      .exit_valid_i (exit_valid_i),
      .exit_value_i (exit_value_i),
      .dump_on_o    (dump_on_o),
      .dump_start_o (dump_start_o),
      .dump_stop_o  (dump_stop_o),
      .dump_seq_o   (dump_seq_o),
      .cycle_cnt_o  (cycle_cnt_o),
      .heartbeat_o  (heartbeat_o),
      .timeout_o    (timeout_o),
      .done_o       (done_o),
      .pass_o       (pass_o),
      .exit_code_o  (exit_code_o),
      .dbg_state_o  (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic [7:0]  mode;
      logic [3:0]  trig;
      logic [3:0]  on;
      logic [3:0]  start;
      logic [3:0]  stop;
      logic [31:0] seq;
   } vec_t;

   localparam int NVEC = 28;
   vec_t vecs[NVEC];

   // scoreboard: {on, start, stop, seq}
   logic [43:0] exp_q[$];

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic wait_cycle(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      rst_ni       = 1'b0;
      mode_i       = '0;
      trig_i       = '0;
      max_cycles_i = '0;
      exit_valid_i = 1'b0;
      exit_value_i = '0;
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cyc    = 0;
   endtask

   task automatic pop_compare();
      logic [43:0] e;
      e = exp_q.pop_front();
      check("dump_on",    64'(dump_on_o),    64'(e[43:40]));
      check("dump_start", 64'(dump_start_o), 64'(e[39:36]));
      check("dump_stop",  64'(dump_stop_o),  64'(e[35:32]));
      check("dump_seq",   64'(dump_seq_o),   64'(e[31:0]));
   endtask

   task automatic fill_vectors();
      vecs[0]  = '{0,  8'h39, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000000};
      vecs[1]  = '{1,  8'h39, 4'h0, 4'h1, 4'h1, 4'h0, 32'h00000000};
      vecs[2]  = '{2,  8'h39, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00000001};
      vecs[3]  = '{10, 8'h39, 4'h2, 4'h1, 4'h0, 4'h0, 32'h00000001};
      vecs[4]  = '{11, 8'h39, 4'h2, 4'h3, 4'h2, 4'h0, 32'h00000001};
      vecs[5]  = '{12, 8'h39, 4'h2, 4'h3, 4'h0, 4'h0, 32'h00000101};
      vecs[6]  = '{20, 8'h39, 4'h0, 4'h3, 4'h0, 4'h0, 32'h00000101};
      vecs[7]  = '{21, 8'h39, 4'h0, 4'h1, 4'h0, 4'h2, 32'h00000101};
      vecs[8]  = '{22, 8'h39, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00000101};
      vecs[9]  = '{30, 8'h39, 4'h2, 4'h1, 4'h0, 4'h0, 32'h00000101};
      vecs[10] = '{31, 8'h39, 4'h2, 4'h3, 4'h2, 4'h0, 32'h00000101};
      vecs[11] = '{32, 8'h39, 4'h0, 4'h3, 4'h0, 4'h0, 32'h00000201};
      vecs[12] = '{33, 8'h39, 4'h0, 4'h1, 4'h0, 4'h2, 32'h00000201};
      vecs[13] = '{40, 8'h39, 4'h4, 4'h1, 4'h0, 4'h0, 32'h00000201};
      vecs[14] = '{41, 8'h39, 4'h0, 4'h5, 4'h4, 4'h0, 32'h00000201};
      vecs[15] = '{42, 8'h39, 4'h0, 4'h5, 4'h0, 4'h0, 32'h00010201};
      vecs[16] = '{43, 8'h39, 4'h0, 4'h1, 4'h0, 4'h4, 32'h00010201};
      vecs[17] = '{50, 8'h39, 4'h4, 4'h1, 4'h0, 4'h0, 32'h00010201};
      vecs[18] = '{51, 8'h39, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00010201};
      vecs[19] = '{52, 8'h39, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00010201};
      vecs[20] = '{55, 8'h29, 4'h4, 4'h1, 4'h0, 4'h0, 32'h00010201};
      vecs[21] = '{56, 8'h29, 4'h4, 4'h1, 4'h0, 4'h0, 32'h00010201};
      vecs[22] = '{57, 8'h29, 4'h4, 4'h5, 4'h4, 4'h0, 32'h00010201};
      vecs[23] = '{58, 8'h29, 4'h0, 4'h5, 4'h0, 4'h0, 32'h00020201};
      vecs[24] = '{59, 8'h29, 4'h0, 4'h1, 4'h0, 4'h4, 32'h00020201};
      vecs[25] = '{60, 8'h28, 4'h0, 4'h1, 4'h0, 4'h0, 32'h00020201};
      vecs[26] = '{61, 8'h28, 4'h0, 4'h0, 4'h0, 4'h1, 32'h00020201};
      vecs[27] = '{62, 8'h28, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00020201};
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int starts;
      logic [31:0] junk;

      // Channel windows: ch0 ON, ch1 TRIG, ch2 ONESHOT then TRIG, ch0 closed by OFF.
      fill_vectors();
      do_reset();
      check("reset_done",    64'(done_o), 64'd0);
      check("reset_timeout", 64'(timeout_o), 64'd0);
      check("reset_code",    64'(exit_code_o), 64'd0);
      for (int i = 0; i < NVEC; i++) begin
         wait_cycle(vecs[i].cyc);
         exp_q.push_back({vecs[i].on, vecs[i].start, vecs[i].stop, vecs[i].seq});
         pop_compare();
         check("cycle_cnt", 64'(cycle_cnt_o), 64'(cyc));
         check("heartbeat", 64'(heartbeat_o), 64'((cyc % HB) == (HB - 1)));
         mode_i = vecs[i].mode;
         trig_i = vecs[i].trig;
      end
      wait_cycle(200);
      check("unlimited_timeout", 64'(timeout_o), 64'd0);

      // Watchdog: limit 500, ch0 ON and ch3 TRIG windows open at expiry.
      do_reset();
      max_cycles_i = 32'd500;
      mode_i = 8'h81;
      trig_i = 4'h8;
      wait_cycle(495);
      check("hb_before_halt", 64'(heartbeat_o), 64'd1);
      wait_cycle(500);
      check("wd_500_timeout", 64'(timeout_o), 64'd0);
      check("wd_500_on",      64'(dump_on_o), 64'h9);
      step();
      check("wd_501_timeout", 64'(timeout_o), 64'd1);
      check("wd_501_cnt",     64'(cycle_cnt_o), 64'd501);
      check("wd_501_stop",    64'(dump_stop_o), 64'd0);
      step();
      check("wd_502_stop",    64'(dump_stop_o), 64'h9);
      check("wd_502_on",      64'(dump_on_o), 64'h0);
      step();
      check("wd_503_stop",    64'(dump_stop_o), 64'h0);
      check("wd_503_state",   64'(dbg_state_o), 64'h0);
      wait_cycle(511);
      check("wd_hb_stopped",  64'(heartbeat_o), 64'd0);
      check("wd_cnt_frozen",  64'(cycle_cnt_o), 64'd501);
      check("wd_no_start",    64'(dump_start_o), 64'h0);
      check("wd_done",        64'(done_o), 64'd0);

      // Exit with nonzero code in the same cycle the watchdog would fire.
      do_reset();
      max_cycles_i = 32'd100;
      wait_cycle(100);
      exit_valid_i = 1'b1;
      exit_value_i = 32'h3;
      step();
      exit_valid_i = 1'b0;
      exit_value_i = '0;
      check("ex_done",    64'(done_o), 64'd1);
      check("ex_pass",    64'(pass_o), 64'd0);
      check("ex_code",    64'(exit_code_o), 64'h3);
      check("ex_timeout", 64'(timeout_o), 64'd0);
      step();
      check("ex_timeout_later", 64'(timeout_o), 64'd0);
      check("ex_cnt_frozen",    64'(cycle_cnt_o), 64'd101);
      exit_valid_i = 1'b1;
      step();
      exit_valid_i = 1'b0;
      check("ex_second_ignored", 64'(exit_code_o), 64'h3);

      // Passing exit, then a later nonzero strobe that must be ignored.
      do_reset();
      wait_cycle(5);
      exit_valid_i = 1'b1;
      step();
      check("pass_done", 64'(done_o), 64'd1);
      check("pass_pass", 64'(pass_o), 64'd1);
      junk = 32'($urandom_range(1, 255));
      exit_value_i = junk;
      step();
      exit_valid_i = 1'b0;
      step();
      check("pass_sticky", 64'(pass_o), 64'd1);
      check("pass_code",   64'(exit_code_o), 64'd0);

      // Reset in the middle of a ch3 window: everything clears, no stop pulse.
      do_reset();
      mode_i = 8'h40;
      wait_cycle(5);
      check("mid_on", 64'(dump_on_o), 64'h8);
      rst_ni = 1'b0;
      step();
      check("rst_on",   64'(dump_on_o), 64'h0);
      check("rst_stop", 64'(dump_stop_o), 64'h0);
      check("rst_seq",  64'(dump_seq_o), 64'h0);
      check("rst_cnt",  64'(cycle_cnt_o), 64'd0);
      step();
      check("rst_stop2", 64'(dump_stop_o), 64'h0);

      // 256 trigger windows on ch3 wrap its sequence index back to 0.
      rst_ni = 1'b1;
      cyc    = 0;
      mode_i = 8'h80;
      starts = 0;
      for (int i = 0; i < 256; i++) begin
         trig_i = 4'h8;
         step();
         trig_i = 4'h0;
         if (dump_start_o[3]) starts++;
         step();
         step();
         step();
         if (i == 254) check("seq_255", 64'(dump_seq_o[31:24]), 64'd255);
      end
      step();
      check("wrap_starts", 64'(starts), 64'd256);
      check("wrap_seq",    64'(dump_seq_o[31:24]), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
